req_queue: RTL and testbench

- Parametrised hall-call request FIFO for the elevator FSM. It sits between the button decoder and the elevator controller, and generalises the fixed two-entry request buffer to DEPTH entries and FLOOR_W-bit floor codes.
- Adds edge-qualified capture, duplicate-request suppression, full/overflow and duplicate status, and an occupancy count.
- The controller reads the head request on dout and retires it with the done completion handshake.

---
 rtl/req_pkg.sv | 34 +++
 rtl/req_queue_rise_det.sv | 23 ++
 rtl/req_queue.sv | 109 ++++++++++
 tb/tb_req_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// Shared request-code definitions for the hall-call queue and its users.
// Named codes describe the default 4-floor build (FLOOR_W = 2).
package req_pkg;

  localparam int FLOOR_W_DEF = 2;
  localparam int REQ_W_DEF   = FLOOR_W_DEF + 1;

  typedef logic [REQ_W_DEF-1:0] req_t;

  // A request code is {dir, floor}: the direction sits above the floor field.
  localparam int DIR_BIT  = FLOOR_W_DEF;
  localparam int FLOOR_HI = FLOOR_W_DEF - 1;
  localparam int FLOOR_LO = 0;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam req_t REQ_NONE = 3'b000;
  localparam req_t REQ_1U   = 3'b001;
  localparam req_t REQ_2U   = 3'b010;
  localparam req_t REQ_3U   = 3'b011;
  localparam req_t REQ_2D   = 3'b110;
  localparam req_t REQ_3D   = 3'b111;
  localparam req_t REQ_4D   = 3'b100;

  function automatic logic req_dir(input req_t r);
    return r[DIR_BIT];
  endfunction

  function automatic logic [FLOOR_HI:FLOOR_LO] req_floor(input req_t r);
    return r[FLOOR_HI:FLOOR_LO];
  endfunction

endpackage

// File: rtl/req_queue_rise_det.sv
// Registered rising-edge detector with a configurable reset value, so a
// level that is already high coming out of reset is not seen as an edge.
module rise_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= INIT;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/req_queue.sv
// Hall-call request FIFO: edge-qualified capture, duplicate suppression,
// overflow reporting and done-rise retirement of the head request.
module req_queue
  import req_pkg::*;
#(
  parameter int FLOOR_W = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [FLOOR_W:0] din,
  output logic [FLOOR_W:0] dout,
  output logic             qEmpty,
  output logic             qFull,
  output logic [CNT_W-1:0] count,
  output logic             dup_o,
  output logic             ovf_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FLOOR_W:0] NONE = '0;

  logic [FLOOR_W:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [FLOOR_W:0] din_q;
  logic             done_rise;

  logic             pop, cand, hit, push, dup, ovf, rem_full;
  logic [PTR_W-1:0] next_rd;
  logic [CNT_W-1:0] next_cnt;
  logic [FLOOR_W:0] next_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rise_det #(.INIT(1'b1)) u_done_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (done),
    .rise  (done_rise)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    pop      = done_rise && (count != '0);
    cand     = (din != NONE) && (din != din_q);
    hit      = 1'b0;
    // The head being popped this cycle no longer blocks a re-press of it.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !(pop && (PTR_W'(i) == rd_ptr)) && (mem[i] == din))
        hit = 1'b1;
    end
    rem_full = (count == CNT_W'(DEPTH)) && !pop;
    dup      = cand && hit;
    push     = cand && !hit && !rem_full;
    ovf      = cand && !hit && rem_full;

    next_rd  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    next_cnt = count;
    if (push && !pop)      next_cnt = count + 1'b1;
    else if (pop && !push) next_cnt = count - 1'b1;

    // A push into an otherwise empty queue lands exactly at the new head.
    if (next_cnt == '0)                  next_head = NONE;
    else if (push && (wr_ptr == next_rd)) next_head = din;
    else                                 next_head = mem[next_rd];
  end

  // NOTE: the entry storage has no reset; the valid bits and count alone
  // decide which slots are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      din_q  <= NONE;
      count  <= '0;
      dout   <= NONE;
      qEmpty <= 1'b1;
      qFull  <= 1'b0;
      dup_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (pop)  valid[rd_ptr] <= 1'b0;
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      rd_ptr <= next_rd;
      din_q  <= din;
      count  <= next_cnt;
      dout   <= next_head;
      qEmpty <= (next_cnt == '0);
      qFull  <= (next_cnt == CNT_W'(DEPTH));
      dup_o  <= dup;
      ovf_o  <= ovf;
    end
  end

endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: a queue-based reference model checked every
// cycle, plus literal expectations at key points of the stimulus.
module tb_req_queue;
  import req_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  req_t       din;
  req_t       dout;
  logic       q_empty, q_full, dup_o, ovf_o;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  req_queue #(.FLOOR_W(2), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .done   (done),
    .din    (din),
    .dout   (dout),
    .qEmpty (q_empty),
    .qFull  (q_full),
    .count  (count),
    .dup_o  (dup_o),
    .ovf_o  (ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue updated from the rules at each rising edge.
  req_t m_q[$];
  req_t m_din_q;
  logic m_done_q;
  logic m_dup, m_ovf;
  bit   started = 0;

  always @(posedge clk) begin
    bit do_pop, is_cand, is_dup;
    if (!rst_n) begin
      m_q.delete();
      m_din_q  = REQ_NONE;
      m_done_q = 1'b1;
      m_dup    = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      do_pop = done && !m_done_q && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      is_cand = (din != REQ_NONE) && (din != m_din_q);
      is_dup  = 0;
      foreach (m_q[i]) if (m_q[i] == din) is_dup = 1;
      m_dup = 1'b0;
      m_ovf = 1'b0;
      if (is_cand) begin
        if (is_dup)                   m_dup = 1'b1;
        else if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else                          m_q.push_back(din);
      end
      m_din_q  = din;
      m_done_q = done;
    end
    started = 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (started) begin
      check("model_dout",  int'(dout),    (m_q.size() > 0) ? int'(m_q[0]) : 0);
      check("model_count", int'(count),   m_q.size());
      check("model_empty", int'(q_empty), int'(m_q.size() == 0));
      check("model_full",  int'(q_full),  int'(m_q.size() == DEPTH));
      check("model_dup",   int'(dup_o),   int'(m_dup));
      check("model_ovf",   int'(ovf_o),   int'(m_ovf));
    end
  end

  // Drive one cycle of inputs; returns 1 ns after the edge that sampled them.
  task automatic cyc(input req_t d, input logic dn);
    din  = d;
    done = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    din   = REQ_NONE;
    done  = 1'b1;
    #2;
    cyc(REQ_NONE, 1'b1);
    cyc(REQ_NONE, 1'b1);
    rst_n = 1'b1;
    cyc(REQ_NONE, 1'b1);
    cyc(REQ_NONE, 1'b1);
    check("idle_count", int'(count), 0);
    check("idle_dout",  int'(dout), 0);
    check("idle_empty", int'(q_empty), 1);

    // Pop on an empty queue is ignored.
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_NONE, 1'b1);
    check("empty_pop_count", int'(count), 0);

    // Held press yields one entry.
    cyc(REQ_1U, 1'b1);
    check("press_count", int'(count), 1);
    check("press_dout",  int'(dout), 3'b001);
    cyc(REQ_1U, 1'b1);
    check("hold_no_dup", int'(dup_o), 0);
    check("hold_count",  int'(count), 1);

    // done 1->0->1 retires the head.
    cyc(REQ_NONE, 1'b0);
    check("busy_keep", int'(dout), 3'b001);
    cyc(REQ_NONE, 1'b1);
    check("retire_empty", int'(q_empty), 1);
    check("retire_dout",  int'(dout), 0);

    // Fill to DEPTH, then overflow.
    cyc(REQ_4D, 1'b0);
    cyc(REQ_2D, 1'b0);
    cyc(REQ_3U, 1'b0);
    cyc(REQ_2U, 1'b0);
    check("fill_count", int'(count), 4);
    check("fill_full",  int'(q_full), 1);
    cyc(REQ_3D, 1'b0);
    check("ovf_pulse", int'(ovf_o), 1);
    check("ovf_count", int'(count), 4);
    cyc(REQ_NONE, 1'b0);
    check("ovf_single", int'(ovf_o), 0);
    check("order_0", int'(dout), 3'b100);

    // Drain in strict FIFO order.
    cyc(REQ_NONE, 1'b1); check("order_1", int'(dout), 3'b110);
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_NONE, 1'b1); check("order_2", int'(dout), 3'b011);
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_NONE, 1'b1); check("order_3", int'(dout), 3'b010);
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_NONE, 1'b1); check("drain_empty", int'(q_empty), 1);
    cyc(REQ_NONE, 1'b0);

    // Duplicate suppression, then re-press of the head being popped.
    cyc(REQ_2D, 1'b0);
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_2D, 1'b0);
    check("dup_pulse", int'(dup_o), 1);
    check("dup_count", int'(count), 1);
    cyc(REQ_NONE, 1'b0);
    check("dup_single", int'(dup_o), 0);
    cyc(REQ_2D, 1'b1);
    check("repress_count", int'(count), 1);
    check("repress_dout",  int'(dout), 3'b110);
    check("repress_nodup", int'(dup_o), 0);
    cyc(REQ_NONE, 1'b0);

    // Wrap-around: fill, pop twice, push twice, then push+pop on full.
    cyc(REQ_1U, 1'b0);
    cyc(REQ_2U, 1'b0);
    cyc(REQ_3U, 1'b0);
    check("wrap_full", int'(q_full), 1);
    cyc(REQ_NONE, 1'b1); check("wrap_pop1", int'(dout), 3'b001);
    cyc(REQ_NONE, 1'b0);
    cyc(REQ_NONE, 1'b1); check("wrap_pop2", int'(dout), 3'b010);
    cyc(REQ_NONE, 1'b0);
    check("wrap_count2", int'(count), 2);
    cyc(REQ_3D, 1'b0);
    cyc(REQ_4D, 1'b0);
    check("wrap_refill", int'(count), 4);
    cyc(REQ_1U, 1'b1);
    check("full_pushpop_count", int'(count), 4);
    check("full_pushpop_dout",  int'(dout), 3'b011);
    check("full_pushpop_noovf", int'(ovf_o), 0);
    cyc(REQ_NONE, 1'b0);

    // Reset mid-operation discards everything; held done is not an edge after.
    rst_n = 1'b0;
    cyc(REQ_1U, 1'b1);
    check("rst_count", int'(count), 0);
    check("rst_dout",  int'(dout), 0);
    rst_n = 1'b1;
    cyc(REQ_1U, 1'b1);
    check("post_rst_push", int'(count), 1);
    cyc(REQ_NONE, 1'b1);
    check("post_rst_nopop", int'(count), 1);
    cyc(REQ_NONE, 1'b1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
